// File: rtl/ob_mk_cnt_arb.sv
`default_nettype none
// ============================================================================
// Module   : ob_mk_cnt_arb
// Brief    : Round-robin arbiter/sequencer sharing one ob_mk_table_cnt count
//            unit between REQ_N requesters. Grants one request at a time,
//            pulses the count command, waits for the unit to go idle (or
//            times out) and returns the registered quantity with the
//            requester id under a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module ob_mk_cnt_arb #(
    parameter int REQ_N     = 2,
    parameter int TIMEOUT_N = 64,
    parameter int QTY_W     = 32,
    localparam int c_ID_W   = (REQ_N > 1) ? $clog2(REQ_N) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REQ_N-1:0]  req_vld,
    output logic [REQ_N-1:0]  req_rdy,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [c_ID_W-1:0] rsp_id,
    output logic [QTY_W-1:0]  rsp_quantity,
    output logic              rsp_err,
    output logic              cnt_cmd_vld,
    input  logic              cnt_busy_w,
    input  logic [QTY_W-1:0]  cnt_rsp_qty_w,
    output logic              tbl_lock,
    output logic              busy
);

    localparam int c_TMO_W = (TIMEOUT_N > 1) ? $clog2(TIMEOUT_N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ID_W-1:0]   r_rr_ptr;
    logic [c_ID_W-1:0]   r_id;
    logic [QTY_W-1:0]    r_qty;
    logic                r_err;
    logic [c_TMO_W-1:0]  r_tmo;

    logic [c_ID_W-1:0]   w_hi_id;
    logic [c_ID_W-1:0]   w_lo_id;
    logic [c_ID_W-1:0]   w_grant_id;
    logic                w_hi_found;
    logic                w_lo_found;
    logic                w_found;
    logic                w_tmo_hit;

    assign w_tmo_hit    = (r_tmo == c_TMO_W'(TIMEOUT_N - 1));
    assign rsp_id       = r_id;
    assign rsp_quantity = r_qty;
    assign rsp_err      = r_err;

    // Round-robin search: lowest requester above the pointer wins, otherwise
    // wrap around to the lowest requester at or below the pointer.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_id    = '0;
        w_lo_id    = '0;
        for (int i = REQ_N - 1; i >= 0; i--) begin
            if (req_vld[i]) begin
                if (c_ID_W'(i) > r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_id    = c_ID_W'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_id    = c_ID_W'(i);
                end
            end
        end
        w_found    = w_hi_found | w_lo_found;
        w_grant_id = w_hi_found ? w_hi_id : w_lo_id;
    end

    // Next-state and state-decoded outputs.
    always_comb begin
        w_state_nxt = r_state;
        req_rdy     = '0;
        cnt_cmd_vld = 1'b0;
        tbl_lock    = 1'b0;
        rsp_vld     = 1'b0;
        busy        = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    req_rdy     = {{(REQ_N-1){1'b0}}, 1'b1} << w_grant_id;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_cmd_vld = 1'b1;
                tbl_lock    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                tbl_lock = 1'b1;
                if (!cnt_busy_w || w_tmo_hit) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_vld = 1'b1;
                if (rsp_rdy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant bookkeeping, timeout counter and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= c_ID_W'(REQ_N - 1);
            r_id     <= '0;
            r_qty    <= '0;
            r_err    <= 1'b0;
            r_tmo    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_id     <= w_grant_id;
                        r_rr_ptr <= w_grant_id;
                    end
                end
                ST_ISSUE: begin
                    r_tmo <= '0;
                end
                ST_WAIT: begin
                    // An idle count unit takes precedence over a coincident timeout.
                    if (!cnt_busy_w) begin
                        r_qty <= cnt_rsp_qty_w;
                        r_err <= 1'b0;
                    end else if (w_tmo_hit) begin
                        r_qty <= '0;
                        r_err <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ob_mk_cnt_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_ob_mk_cnt_arb
// Brief    : Self-checking bench for ob_mk_cnt_arb with a stub count unit and
//            a transaction-level round-robin / latency reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ob_mk_cnt_arb;

    localparam int REQ_N     = 3;
    localparam int TIMEOUT_N = 64;
    localparam int QTY_W     = 32;
    localparam int ID_W      = $clog2(REQ_N);

    logic              clk = 1'b0;
    logic              rst_n;
    logic [REQ_N-1:0]  req_vld;
    logic [REQ_N-1:0]  req_rdy;
    logic              rsp_vld;
    logic              rsp_rdy;
    logic [ID_W-1:0]   rsp_id;
    logic [QTY_W-1:0]  rsp_quantity;
    logic              rsp_err;
    logic              cnt_cmd_vld;
    logic              cnt_busy_w;
    logic [QTY_W-1:0]  cnt_rsp_qty_w;
    logic              tbl_lock;
    logic              busy;

    int n_checks = 0;
    int n_fail   = 0;
    int mdl_ptr;

    // Stub count unit: stays busy for stub_d cycles after a command, then
    // presents stub_q; drives junk on the quantity bus while busy.
    int               stub_d;
    logic [QTY_W-1:0] stub_q;
    int               stub_cnt;
    logic [QTY_W-1:0] stub_q_r;
    logic [QTY_W-1:0] junk;

    always #5 clk = ~clk;

    ob_mk_cnt_arb #(
        .REQ_N     (REQ_N),
        .TIMEOUT_N (TIMEOUT_N),
        .QTY_W     (QTY_W)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .rsp_vld       (rsp_vld),
        .rsp_rdy       (rsp_rdy),
        .rsp_id        (rsp_id),
        .rsp_quantity  (rsp_quantity),
        .rsp_err       (rsp_err),
        .cnt_cmd_vld   (cnt_cmd_vld),
        .cnt_busy_w    (cnt_busy_w),
        .cnt_rsp_qty_w (cnt_rsp_qty_w),
        .tbl_lock      (tbl_lock),
        .busy          (busy)
    );

    always @(posedge clk) junk <= QTY_W'($urandom);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stub_cnt <= 0;
            stub_q_r <= '0;
        end else if (cnt_cmd_vld) begin
            stub_cnt <= stub_d;
            stub_q_r <= stub_q;
        end else if (stub_cnt > 0) begin
            stub_cnt <= stub_cnt - 1;
        end
    end

    assign cnt_busy_w    = (stub_cnt != 0);
    assign cnt_rsp_qty_w = cnt_busy_w ? junk : stub_q_r;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference round robin: first set request strictly after the last served one.
    function automatic int mdl_grant(input logic [REQ_N-1:0] pat);
        for (int k = 1; k <= REQ_N; k++) begin
            if (pat[(mdl_ptr + k) % REQ_N]) return (mdl_ptr + k) % REQ_N;
        end
        return -1;
    endfunction

    task automatic do_txn(input logic [REQ_N-1:0] pat, input int d,
                          input logic [QTY_W-1:0] q, input int hold);
        int               exp_id;
        int               cyc;
        int               cmd_n;
        int               lock_n;
        bit               exp_err;
        logic [REQ_N-1:0] exp_gnt;
        logic [ID_W-1:0]  h_id;
        logic [QTY_W-1:0] h_q;
        logic             h_err;
        req_vld = pat;
        stub_d  = d;
        stub_q  = q;
        #1;
        exp_id = mdl_grant(pat);
        exp_gnt = '0;
        exp_gnt[exp_id] = 1'b1;
        chk("grant", req_rdy, exp_gnt);
        chk("idle_busy", busy, 0);
        tick();
        mdl_ptr = exp_id;
        req_vld = REQ_N'($urandom);
        #1;
        cyc    = 1;
        cmd_n  = 0;
        lock_n = 0;
        while (!rsp_vld && cyc < 200) begin
            chk("no_grant_when_busy", req_rdy, 0);
            if (cnt_cmd_vld) begin
                cmd_n++;
                chk("cmd_unit_idle", cnt_busy_w, 0);
            end
            lock_n += int'(tbl_lock);
            tick();
            #1;
            cyc++;
        end
        exp_err = (d >= TIMEOUT_N);
        chk("latency", cyc, exp_err ? TIMEOUT_N + 2 : d + 3);
        chk("rsp_id", rsp_id, exp_id);
        chk("rsp_quantity", rsp_quantity, exp_err ? '0 : q);
        chk("rsp_err", rsp_err, exp_err);
        chk("cmd_pulses", cmd_n, 1);
        chk("lock_cycles", lock_n, exp_err ? TIMEOUT_N + 1 : d + 2);
        chk("lock_in_resp", tbl_lock, 0);
        h_id  = rsp_id;
        h_q   = rsp_quantity;
        h_err = rsp_err;
        for (int h = 0; h < hold; h++) begin
            tick();
            req_vld = '1;
            #1;
            chk("hold_vld", rsp_vld, 1);
            chk("hold_payload", {rsp_id, rsp_quantity, rsp_err}, {h_id, h_q, h_err});
            chk("hold_no_grant", req_rdy, 0);
        end
        req_vld = '1;
        rsp_rdy = 1'b1;
        #1;
        chk("hs_no_grant", req_rdy, 0);
        tick();
        rsp_rdy = 1'b0;
        req_vld = '0;
        #1;
        chk("post_hs_vld", rsp_vld, 0);
        chk("post_hs_busy", busy, 0);
    endtask

    initial begin
        rst_n   = 1'b0;
        req_vld = '0;
        rsp_rdy = 1'b0;
        stub_d  = 0;
        stub_q  = '0;
        repeat (3) tick();
        rst_n = 1'b1;
        mdl_ptr = REQ_N - 1;
        #1;
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_rsp_vld", rsp_vld, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_qty", rsp_quantity, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_cmd", cnt_cmd_vld, 0);
        chk("rst_lock", tbl_lock, 0);
        chk("rst_busy", busy, 0);
        tick();

        // Single requester, four-cycle count unit -> response at T+7.
        do_txn(3'b001, 4, 32'h1234, 0);
        // All requesters held: rotation through every id.
        for (int t = 0; t < 4; t++) do_txn('1, 2 + t, QTY_W'($urandom), 0);
        // Long backpressure.
        do_txn(3'b110, 3, 32'hCAFE, 10);
        // Timeout boundaries and recovery.
        do_txn(3'b100, TIMEOUT_N + 1, 32'hDEAD, 1);
        do_txn(3'b011, TIMEOUT_N, 32'hBEEF, 0);
        do_txn(3'b101, TIMEOUT_N - 1, 32'h5555, 0);
        do_txn(3'b001, 0, 32'hA5A5, 2);

        // Asynchronous reset while waiting on the count unit.
        req_vld = 3'b010;
        stub_d  = 20;
        stub_q  = 32'h7777;
        tick();
        req_vld = '0;
        repeat (5) tick();
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_lock", tbl_lock, 0);
        chk("arst_rsp_vld", rsp_vld, 0);
        chk("arst_rsp_id", rsp_id, 0);
        chk("arst_rsp_qty", rsp_quantity, 0);
        chk("arst_req_rdy", req_rdy, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        mdl_ptr = REQ_N - 1;
        do_txn(3'b010, 5, 32'h00C0FFEE, 0);

        // Randomized traffic.
        for (int t = 0; t < 30; t++) begin
            do_txn(REQ_N'($urandom_range(1, (1 << REQ_N) - 1)),
                   int'($urandom_range(0, 12)), QTY_W'($urandom),
                   int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
